// File: rtl/div_pkg.sv
// div_pkg: shared encodings and constants for the divider controller.
package div_pkg;
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_MOD  = 2'b01,
        OP_DIVU = 2'b10,
        OP_MODU = 2'b11
    } op_e;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_ABORT = 2'd2,
        S_DONE  = 2'd3
    } state_e;
    localparam logic [31:0] DIV0_QUOT   = 32'hFFFF_FFFF;
    localparam int          DEF_TIMEOUT = 40;
endpackage

// File: rtl/div_ctrl.sv
// div_ctrl: request/response sequencer around an iterative divider,
// with divide-by-zero shortcut, flush abort and busy timeout.
module div_ctrl
    import div_pkg::*;
#(
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             div_clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_x,
    input  logic [31:0]      req_y,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             div,
    output logic             div_signed,
    output logic [31:0]      x,
    output logic [31:0]      y,
    input  logic [31:0]      s,
    input  logic [31:0]      r,
    input  logic             complete,
    output logic             busy
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [31:0]      x_q, x_d, y_q, y_d, data_q, data_d;
    logic             sgn_q, sgn_d, sel_q, sel_d, err_q, err_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             hs;

    assign hs = req_valid & req_ready & ~flush;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        sgn_d   = sgn_q;
        sel_d   = sel_q;
        tag_d   = tag_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (hs) begin
                tag_d = req_tag;
                sel_d = req_op[0];
                err_d = 1'b0;
                // divide-by-zero answers immediately and leaves the divider operands alone
                if (req_y != '0) begin
                    state_d = S_BUSY;
                    x_d     = req_x;
                    y_d     = req_y;
                    sgn_d   = ~req_op[1];
                    cnt_d   = '0;
                end else begin
                    state_d = S_DONE;
                    data_d  = req_op[0] ? req_x : DIV0_QUOT;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (flush) state_d = S_ABORT;
                else if (complete) begin
                    state_d = S_DONE;
                    data_d  = sel_q ? r : s;
                    err_d   = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_DONE;
                    data_d  = '0;
                    err_d   = 1'b1;
                end
            end
            S_ABORT: state_d = S_IDLE;
            S_DONE:  if (flush | rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge div_clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            sgn_q   <= 1'b0;
            sel_q   <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sgn_q   <= sgn_d;
            sel_q   <= sel_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready  = state_q == S_IDLE;
    assign busy       = state_q != S_IDLE;
    assign div        = state_q == S_BUSY;
    assign rsp_valid  = state_q == S_DONE;
    assign rsp_data   = data_q;
    assign rsp_tag    = tag_q;
    assign rsp_err    = err_q;
    assign x          = x_q;
    assign y          = y_q;
    assign div_signed = sgn_q;
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed checks of div_ctrl against a behavioural divider
// whose latency can be stretched or disabled.
module tb_div_ctrl;
    localparam int TAG_W   = 5;
    localparam int TIMEOUT = 40;

    logic             div_clk = 1'b0;
    logic             resetn  = 1'b1;
    logic             req_valid = 1'b0, req_ready, flush = 1'b0;
    logic [1:0]       req_op = '0;
    logic [31:0]      req_x = '0, req_y = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0]      rsp_data, x, y, s, r;
    logic [TAG_W-1:0] rsp_tag;
    logic             div, div_signed, complete, busy;

    int  checks = 0, errors = 0;
    int  lat = 3, mcnt = 0, cyc;
    logic model_en = 1'b1, sgn_hi, div_hi, flag;

    div_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .div_clk(div_clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x(req_x), .req_y(req_y), .req_tag(req_tag), .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .div(div), .div_signed(div_signed), .x(x), .y(y),
        .s(s), .r(r), .complete(complete), .busy(busy)
    );

    always #5 div_clk = ~div_clk;

    // behavioural divider: completes on the (lat+1)-th cycle of div high
    always_ff @(posedge div_clk) mcnt <= div ? mcnt + 1 : 0;
    assign complete = model_en && div && (mcnt == lat);
    assign s = (y == 0) ? 32'd0 : div_signed ? 32'($signed(x) / $signed(y)) : x / y;
    assign r = (y == 0) ? 32'd0 : div_signed ? 32'($signed(x) % $signed(y)) : x % y;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge div_clk);
        #1;
    endtask

    task automatic do_req(input logic [1:0] op, input logic [31:0] xv, input logic [31:0] yv,
                          input logic [TAG_W-1:0] tg);
        req_valid = 1'b1; req_op = op; req_x = xv; req_y = yv; req_tag = tg;
        sgn_hi = 1'b0; div_hi = 1'b0;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int max, output int n);
        n = 0;
        while (!rsp_valid && n < max) begin
            if (div) div_hi = 1'b1;
            if (div && div_signed) sgn_hi = 1'b1;
            step();
            n++;
        end
        chk("rsp_valid_arrives", {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic accept();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #2 resetn = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_div", {31'd0, div}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_tag", {27'd0, rsp_tag}, 32'd0);
        chk("rst_xy", x | y, 32'd0);
        chk("rst_div_signed", {31'd0, div_signed}, 32'd0);
        step(); step();
        resetn = 1'b1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

        // signed divide / remainder
        do_req(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3);
        chk("divw_div_t1", {31'd0, div}, 32'd1);
        chk("divw_req_ready", {31'd0, req_ready}, 32'd0);
        chk("divw_x", x, 32'hFFFF_FFF9);
        wait_rsp(20, cyc);
        chk("divw_latency", cyc, 32'd4);
        chk("divw_data", rsp_data, 32'hFFFF_FFFD);
        chk("divw_tag", {27'd0, rsp_tag}, 32'd3);
        chk("divw_err", {31'd0, rsp_err}, 32'd0);
        chk("divw_signed", {31'd0, sgn_hi}, 32'd1);
        accept();
        chk("divw_idle", {30'd0, rsp_valid, req_ready}, 32'd1);
        do_req(2'b01, 32'hFFFF_FFF9, 32'd2, 5'd4);
        wait_rsp(20, cyc);
        chk("modw_data", rsp_data, 32'hFFFF_FFFF);
        chk("modw_tag", {27'd0, rsp_tag}, 32'd4);
        accept();

        // unsigned divide / remainder
        do_req(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd5);
        wait_rsp(20, cyc);
        chk("divwu_data", rsp_data, 32'h7FFF_FFFC);
        chk("divwu_signed", {31'd0, sgn_hi}, 32'd0);
        accept();
        do_req(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd6);
        wait_rsp(20, cyc);
        chk("modwu_data", rsp_data, 32'h0000_0001);
        chk("modwu_signed", {31'd0, sgn_hi}, 32'd0);
        accept();

        // divide by zero
        do_req(2'b01, 32'd5, 32'd0, 5'd7);
        chk("dz_mod_valid", {31'd0, rsp_valid}, 32'd1);
        chk("dz_mod_data", rsp_data, 32'd5);
        chk("dz_mod_err", {31'd0, rsp_err}, 32'd0);
        chk("dz_div_low", {31'd0, div}, 32'd0);
        chk("dz_x_held", x, 32'hFFFF_FFF9);
        accept();
        do_req(2'b00, 32'd5, 32'd0, 5'd8);
        chk("dz_div_valid", {31'd0, rsp_valid}, 32'd1);
        chk("dz_div_data", rsp_data, 32'hFFFF_FFFF);
        chk("dz_div_low2", {31'd0, div}, 32'd0);
        accept();

        // flush on the 10th BUSY cycle
        lat = 15;
        do_req(2'b00, 32'd50, 32'd3, 5'd1);
        for (int i = 0; i < 9; i++) step();
        chk("fl_busy10_div", {31'd0, div}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_abort", {28'd0, div, busy, rsp_valid, req_ready}, 32'b0100);
        step();
        chk("fl_idle", {28'd0, div, busy, rsp_valid, req_ready}, 32'b0001);
        lat = 3;
        do_req(2'b10, 32'd100, 32'd7, 5'd9);
        wait_rsp(20, cyc);
        chk("fl_next_data", rsp_data, 32'd14);
        chk("fl_next_tag", {27'd0, rsp_tag}, 32'd9);
        accept();

        // stall in DONE then drop with flush
        do_req(2'b11, 32'd100, 32'd7, 5'd10);
        wait_rsp(20, cyc);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("st_valid", {31'd0, rsp_valid}, 32'd1);
            chk("st_data", rsp_data, 32'd2);
            chk("st_tag", {27'd0, rsp_tag}, 32'd10);
            chk("st_req_ready", {31'd0, req_ready}, 32'd0);
        end
        flush = 1'b1; rsp_ready = 1'b1;
        step();
        flush = 1'b0; rsp_ready = 1'b0;
        chk("st_dropped", {30'd0, rsp_valid, req_ready}, 32'd1);

        // flush in IDLE blocks the handshake
        req_valid = 1'b1; req_y = 32'd1; flush = 1'b1;
        step();
        req_valid = 1'b0; flush = 1'b0;
        chk("idle_flush", {30'd0, busy, req_ready}, 32'd1);

        // timeout
        model_en = 1'b0;
        do_req(2'b00, 32'd1, 32'd1, 5'd12);
        wait_rsp(100, cyc);
        chk("to_cycles", cyc, TIMEOUT);
        chk("to_err", {31'd0, rsp_err}, 32'd1);
        chk("to_data", rsp_data, 32'd0);
        chk("to_tag", {27'd0, rsp_tag}, 32'd12);
        accept();
        model_en = 1'b1;

        // complete coincident with flush
        do_req(2'b00, 32'd9, 32'd3, 5'd13);
        step(); step(); step();
        chk("cf_complete", {31'd0, complete}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("cf_abort", {29'd0, div, busy, rsp_valid}, 32'b010);
        step();
        chk("cf_idle", {30'd0, rsp_valid, req_ready}, 32'd1);

        // reset mid-BUSY
        do_req(2'b10, 32'd100, 32'd7, 5'd11);
        step();
        resetn = 1'b0;
        #1;
        chk("mr_state", {29'd0, busy, div, rsp_valid}, 32'd0);
        chk("mr_x", x, 32'd0);
        resetn = 1'b1;
        flag = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (rsp_valid || busy) flag = 1'b1;
        end
        chk("mr_no_rsp", {31'd0, flag}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
